// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction-cache metadata store.
//   flush_state_e : flush sequencer states (idle / sweeping every set)
//   way_lsb()     : bit offset of a way's payload inside the packed dataout bus
// ---------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } flush_state_e;

    // Way w occupies bits [w*width +: width] of the packed payload bus.
    function automatic int unsigned way_lsb(input int unsigned way, input int unsigned width);
        return way * width;
    endfunction

endpackage

// File: rtl/icache_way_bank.sv
// ---------------------------------------------------------------------------
// icache_way_bank
// One way of the metadata store: a payload array and a valid array indexed by
// set, with a registered read port that forwards same-cycle writes.
//   clk, rst        : clock, synchronous active-high reset (clears everything)
//   read, rindex    : capture set rindex into dout/vout
//   load, windex,
//   datain          : write payload and set valid
//   clr, cindex     : clear valid (invalidate or flush sweep); load wins on
//                     the same set
//   dout, vout      : registered payload and valid of the last read
// ---------------------------------------------------------------------------
module icache_way_bank #(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               read,
    input  logic [S_INDEX-1:0] rindex,
    input  logic               load,
    input  logic [S_INDEX-1:0] windex,
    input  logic [WIDTH-1:0]   datain,
    input  logic               clr,
    input  logic [S_INDEX-1:0] cindex,
    output logic [WIDTH-1:0]   dout,
    output logic               vout
);

    localparam int NUM_SETS = 1 << S_INDEX;

    (* ramstyle = "logic" *) logic [WIDTH-1:0] data_q [NUM_SETS];
    logic [NUM_SETS-1:0] valid_q;

    logic [WIDTH-1:0] dout_q;
    logic             vout_q;
    logic [WIDTH-1:0] rd_data_d;
    logic             rd_valid_d;

    // Read-side forwarding: a same-cycle load beats a same-cycle clear,
    // which beats the stored contents.
    always_comb begin
        rd_data_d  = data_q[rindex];
        rd_valid_d = valid_q[rindex];
        if (load && (windex == rindex)) begin
            rd_data_d  = datain;
            rd_valid_d = 1'b1;
        end else if (clr && (cindex == rindex)) begin
            rd_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                data_q[s] <= '0;
            end
            valid_q <= '0;
            dout_q  <= '0;
            vout_q  <= 1'b0;
        end else begin
            // Clear first so a load to the same set overrides it.
            if (clr) begin
                valid_q[cindex] <= 1'b0;
            end
            if (load) begin
                data_q[windex]  <= datain;
                valid_q[windex] <= 1'b1;
            end
            if (read) begin
                dout_q <= rd_data_d;
                vout_q <= rd_valid_d;
            end
        end
    end

    assign dout = dout_q;
    assign vout = vout_q;

endmodule

// File: rtl/icache_meta_array.sv
// ---------------------------------------------------------------------------
// icache_meta_array
// N-way instruction-cache metadata store with a flush sequencer.
//   clk, rst          : clock, synchronous active-high reset
//   read, rindex      : registered lookup of one set across all ways
//   load, windex,
//   wmask, datain     : write payload + set valid in the selected ways
//   inval, iindex,
//   imask             : clear valid in the selected ways
//   flush             : start a sweep clearing every set's valid bits
//   busy              : sweep in progress (load/inval/flush ignored)
//   dataout           : registered payloads, way w at [w*WIDTH +: WIDTH]
//   validout          : registered valids (zero for reads taken mid-sweep)
// ---------------------------------------------------------------------------
module icache_meta_array
    import icache_pkg::*;
#(
    parameter int S_INDEX = 3,
    parameter int WIDTH   = 1,
    parameter int WAYS    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  read,
    input  logic [S_INDEX-1:0]    rindex,
    input  logic                  load,
    input  logic [S_INDEX-1:0]    windex,
    input  logic [WAYS-1:0]       wmask,
    input  logic [WIDTH-1:0]      datain,
    input  logic                  inval,
    input  logic [S_INDEX-1:0]    iindex,
    input  logic [WAYS-1:0]       imask,
    input  logic                  flush,
    output logic                  busy,
    output logic [WAYS*WIDTH-1:0] dataout,
    output logic [WAYS-1:0]       validout
);

    localparam logic [S_INDEX-1:0] LAST_SET = '1;

    flush_state_e       state_q;
    logic [S_INDEX-1:0] cnt_q;
    logic               busy_q;
    // Remembers whether the read now held in the output registers was taken
    // during a sweep, so its valids stay masked for as long as it is held.
    logic               force_q;

    logic               sweep;
    logic [WAYS-1:0]    bank_load;
    logic [WAYS-1:0]    bank_clr;
    logic [S_INDEX-1:0] bank_cindex;
    logic [WAYS-1:0]    bank_vout;

    assign sweep = (state_q == ST_SWEEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            force_q <= 1'b0;
        end else begin
            if (read) begin
                force_q <= sweep;
            end
            case (state_q)
                ST_IDLE: begin
                    if (flush) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SWEEP: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_SET) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // The sweep owns the clear port of every bank; invalidates are dropped
    // while it runs, as are loads.
    assign bank_cindex = sweep ? cnt_q : iindex;

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
            assign bank_load[gi] = load & wmask[gi] & ~sweep;
            assign bank_clr[gi]  = sweep | (inval & imask[gi]);

            icache_way_bank #(
                .S_INDEX (S_INDEX),
                .WIDTH   (WIDTH)
            ) u_bank (
                .clk    (clk),
                .rst    (rst),
                .read   (read),
                .rindex (rindex),
                .load   (bank_load[gi]),
                .windex (windex),
                .datain (datain),
                .clr    (bank_clr[gi]),
                .cindex (bank_cindex),
                .dout   (dataout[way_lsb(gi, WIDTH) +: WIDTH]),
                .vout   (bank_vout[gi])
            );
        end
    endgenerate

    assign validout = bank_vout & {WAYS{~force_q}};
    assign busy     = busy_q;

endmodule

// File: doc/icache_meta_array.md
# icache_meta_array

Parametrised N-way metadata store for the instruction cache: one register array per way, each entry holding a WIDTH-bit payload (tag, LRU bits, etc.) plus a valid bit. It provides a registered read with write-through forwarding, per-way masked writes, single-entry invalidation, and a multi-cycle flush sequencer that sweeps every set. It sits beside the icache datapath and is driven by the icache control FSM.

## Interface

Parameters:

- S_INDEX, 3, set index width; NUM_SETS = 2**S_INDEX
- WIDTH, 1, payload bits per way entry
- WAYS, 2, associativity (1..8)

Ports:

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- read  in  1  capture rindex lookup into output registers
- rindex  in  S_INDEX  read set
- load  in  1  write datain to windex in the ways selected by wmask, and set valid
- windex  in  S_INDEX  write set
- wmask  in  WAYS  one-hot or multi-hot way select for load
- datain  in  WIDTH  write payload
- inval  in  1  clear valid of iindex in the ways selected by imask
- iindex  in  S_INDEX  invalidate set
- imask  in  WAYS  way select for inval
- flush  in  1  start a full-array valid sweep
- busy  out  1  flush sweep in progress
- dataout  out  WAYS*WIDTH  registered payloads; way w occupies bits [w*WIDTH +: WIDTH]
- validout  out  WAYS  registered valid bits

## Operation

- Reset: all payloads = 0, all valids = 0, dataout = 0, validout = 0, busy = 0, sweep counter = 0, FSM = IDLE.
- Read: when read = 1, dataout and validout load from set rindex. When read = 0, they hold their previous value.
- Forwarding, per way w: if load, wmask[w] and windex == rindex, way w returns datain with valid 1.
  - Else, if inval, imask[w] and iindex == rindex, way w returns stored payload with valid 0.
  - Else, way w returns stored contents.
- Load vs inval on the same set and way in the same cycle: load wins, so valid ends at 1.
- FSM IDLE: flush = 1 moves to SWEEP with counter = 0.
- FSM SWEEP: each cycle clears the valid bit of all ways at set counter, then increments.
  - After set NUM_SETS-1 the counter wraps to 0 and the FSM returns to IDLE.
  - Payloads are untouched.
- busy = 1 exactly while in SWEEP.
- During SWEEP:
  - load and inval are ignored; the controller must wait for busy = 0.
  - flush is ignored.
  - read is still accepted, but validout is forced to all-zero.
- rst in any state returns to IDLE with everything cleared on the next edge.
- Width rules: index compares are full S_INDEX bits; the counter is S_INDEX bits and wraps naturally.

## Timing

- Read latency is 1 cycle: read at edge t gives dataout/validout valid after edge t.
- Write visible to a same-cycle read through forwarding; visible to later reads from the array.
- flush sampled at edge t: busy = 1 after edge t.
  - Set k is cleared at edge t+1+k.
  - busy = 0 after edge t+NUM_SETS, so busy is high for exactly NUM_SETS cycles.
- A flush pulse during busy is not queued.
- No combinational path from inputs to outputs.

## Structure

- Shared package icache_pkg:
  - flush FSM state enum (IDLE, SWEEP)
  - a helper function computing the way slice offset
- Sub-module icache_way_bank: holds one way's payload and valid arrays, with ports:
  - read/rindex
  - load/windex/datain
  - clr/cindex for inval and sweep, with load priority
  - registered dout and vout
- icache_meta_array instantiates WAYS banks through a generate loop. It owns the FSM, the sweep counter, the mask decode and the flush-forced valid masking.
- Payload storage is flip-flop registers, with the synthesis ramstyle attribute set to "logic".

## Test plan

- Reset, then read set 5 with all ways -> dataout = 0, validout = 0, busy = 0.
- WIDTH=20, WAYS=2: load set 3 wmask=2'b10 data 0xABCDE, then read set 3 -> way1 = 0xABCDE valid 1, way0 valid 0.
- Same-cycle load and read, set 6, wmask=2'b01, data 0x12345 -> next cycle way0 = 0x12345 valid 1. Also assert load+inval on the same set and way -> valid stays 1.
- Fill all 8 sets in both ways, then pulse flush:
  - busy is high exactly 8 cycles.
  - Reads during the sweep return validout = 0.
  - Loads during the sweep have no effect.
  - After busy falls, every set reads valid 0 and the payloads are unchanged.
- Assert rst on the 3rd cycle of the sweep -> busy = 0 next cycle and all state is cleared. A following flush runs the full 8 cycles.
- inval set 2 imask=2'b11 after loading it -> both ways read valid 0, and a same-cycle read of set 2 shows valid 0.
